// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues instruction-memory reads,
// registers the fetched word and computes the next PC (seq/branch/jump/jr).
module instr_fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        pc_en,
    input  logic        iREN,
    input  logic [1:0]  PCSrc,
    input  logic [15:0] immediate,
    input  logic [25:0] immediate26,
    input  logic [31:0] jr_addr,
    input  logic        halt,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic        imemREN,
    output logic [31:0] iaddr,
    output logic [31:0] instruction,
    output logic        instr_valid
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        VALID  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    logic [31:0] pc_plus4;
    logic [31:0] br_offset;
    logic [31:0] pc_next;

    // Next-PC selection; all adds wrap naturally at 32 bits.
    always_comb begin
        pc_plus4  = pc_q + 32'd4;
        br_offset = {{14{immediate[15]}}, immediate, 2'b00};
        pc_next   = pc_plus4;
        case (PCSrc)
            2'b00:   pc_next = pc_plus4;
            2'b01:   pc_next = pc_plus4 + br_offset;
            2'b10:   pc_next = {pc_plus4[31:28], immediate26, 2'b00};
            2'b11:   pc_next = jr_addr & 32'hFFFF_FFFC;
            default: pc_next = pc_plus4;
        endcase
    end

    // FSM next-state and datapath enables; control inputs only matter in VALID.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        imemREN = 1'b0;
        case (state_q)
            FETCH: begin
                imemREN = iREN;
                if (iREN && !iwait) begin
                    instr_d = iload;
                    state_d = VALID;
                end
            end
            VALID: begin
                // halt wins over pc_en so the halting instruction's PC is kept
                if (halt) begin
                    state_d = HALTED;
                end else if (pc_en) begin
                    pc_d    = pc_next;
                    state_d = FETCH;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= FETCH;
            pc_q    <= PC_INIT;
            instr_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign iaddr       = pc_q;
    assign instruction = instr_q;
    // The held word stays unconsumed while halted as well as in VALID.
    assign instr_valid = (state_q != FETCH);

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port CLK  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port nRST  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port pc_en  input  1  control unit permits PC advance.
REQ-005 SHALL have port iREN  input  1  control unit instruction-read enable.
REQ-006 SHALL have port PCSrc  input  2  next-PC select: 00 seq, 01 branch, 10 jump, 11 register.
REQ-007 SHALL have port immediate  input  16  branch offset, in words.
REQ-008 SHALL have port immediate26  input  26  jump target field.
REQ-009 SHALL have port jr_addr  input  32  register-jump target (rs data).
REQ-010 SHALL have port halt  input  1  decoded halt; freezes fetch.
REQ-011 SHALL have port iwait  input  1  instruction memory busy.
REQ-012 SHALL have port iload  input  32  instruction memory read data.
REQ-013 SHALL have port imemREN  output  1  instruction memory read request.
REQ-014 SHALL have port iaddr  output  32  instruction memory address; always equals PC.
REQ-015 SHALL have port instruction  output  32  registered instruction driven to control unit.
REQ-016 SHALL have port instr_valid  output  1  instruction holds a fetched word not yet consumed.

Function
REQ-017 SHALL implement FSM states FETCH, VALID, HALTED.
REQ-018 In FETCH, imemREN SHALL equal iREN (combinational); FSM SHALL stay in FETCH while iREN=0 or iwait=1.
REQ-019 In FETCH with iREN=1 and iwait=0, SHALL latch iload into instruction at that edge and enter VALID; instr_valid=1 from the next cycle.
REQ-020 In VALID and HALTED, imemREN SHALL be 0.
REQ-021 In VALID with halt=1, SHALL enter HALTED; PC and instruction frozen; halt has priority over pc_en.
REQ-022 In VALID with halt=0 and pc_en=1, SHALL load next PC at that edge, enter FETCH, and drop instr_valid next cycle.
REQ-023 In VALID with halt=0 and pc_en=0, SHALL hold PC, instruction, state.
REQ-024 Next PC, PCSrc=00: PC+4.
REQ-025 Next PC, PCSrc=01: PC+4 + (sign-extended immediate << 2).
REQ-026 Next PC, PCSrc=10: {PC+4[31:28], immediate26, 2'b00}.
REQ-027 Next PC, PCSrc=11: {jr_addr[31:2], 2'b00}; low bits forced to zero.
REQ-028 All PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0; negative offsets wrap likewise.
REQ-029 pc_en, PCSrc, immediate, immediate26, jr_addr SHALL be ignored outside VALID.
REQ-030 HALTED SHALL be exited only by reset.
REQ-031 instruction SHALL change only on a FETCH completion or reset.

Reset
REQ-032 On a rising edge with nRST=0: PC=PC_INIT, instruction=0, state=FETCH; consequently instr_valid=0, iaddr=PC_INIT.
REQ-033 Reset SHALL dominate all other inputs, including mid-fetch with iwait=1 and in HALTED; any pending fetch is abandoned, and the read restarts at PC_INIT with imemREN following iREN from the first cycle after reset.
REQ-034 Between nRST assertion and the next edge, outputs hold their prior values (synchronous reset).

Verification
REQ-035 Reset, iREN=1, iwait=1 for 3 cycles then 0, iload=32'h2401_0005 -> imemREN high 4 cycles, iaddr=0, instruction=32'h2401_0005 and instr_valid=1 next cycle.
REQ-036 VALID at PC=32'h0000_0010, pc_en=1, PCSrc=01, immediate=16'hFFFE -> PC=32'h0000_000C, back in FETCH.
REQ-037 VALID at PC=32'h1000_0040, PCSrc=10, immediate26=26'h000_0100 -> PC=32'h1000_0400; PCSrc=11, jr_addr=32'h0000_0123 -> PC=32'h0000_0120.
REQ-038 PC=32'hFFFF_FFFC, PCSrc=00, pc_en=1 -> PC=0.
REQ-039 VALID with halt=1 and pc_en=1 -> HALTED, PC unchanged, imemREN=0 for 10+ cycles; then nRST=0 one edge -> PC=PC_INIT, instr_valid=0.
REQ-040 nRST=0 during FETCH with iwait=1 -> next cycle iaddr=PC_INIT, instruction=0, no stale iload captured.
